// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and helpers for the register file scoreboard slice.
//   DATA_W_DEF / NUM_REGS_DEF / NUM_RD_DEF : default build parameters
//   regResetValue(idx)                      : reset contents of register idx
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 16;
    localparam int NUM_RD_DEF   = 2;

    // Each register comes out of reset holding its own index, which makes
    // a freshly reset file easy to recognise on a read port.
    function automatic logic [DATA_W_DEF-1:0] regResetValue(input int idx);
        return DATA_W_DEF'(idx);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// regfile_if
// Bundles the read, writeback, issue and status signals of the scoreboard.
//   master : the pipeline side (drives addresses, writeback, issue, flush)
//   slave  : the register file (returns read data, busy flags, status)
//   rd_addr/rd_data/rd_busy are packed per port: port k at [k*W +: W].
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wb_en;
    logic [AW-1:0]            wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     flush;
    logic [NUM_REGS-1:0]      busy_vec;
    logic [AW:0]              pend_cnt;

    modport master (
        output rd_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_vec, pend_cnt
    );

    modport slave (
        input  rd_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_vec, pend_cnt
    );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port
// One combinational read port: register mux plus busy lookup.
// Build option: REGFILE_BYPASS_EN adds a same-cycle forward of the
// writeback value (and its busy effect) when the addresses match.
//   i_addr            : register index to read
//   i_regs / i_busy   : stored register contents and pending marks
//   i_wb*/i_iss*      : writeback/issue request (bypass build only)
//   o_data / o_busy   : read value and pending flag for i_addr
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic [$clog2(NUM_REGS)-1:0] i_addr,
    input  logic [DATA_W-1:0]           i_regs [NUM_REGS],
    input  logic [NUM_REGS-1:0]         i_busy,
`ifdef REGFILE_BYPASS_EN
    input  logic                        i_wbEn,
    input  logic [$clog2(NUM_REGS)-1:0] i_wbAddr,
    input  logic [DATA_W-1:0]           i_wbData,
    input  logic                        i_issEn,
    input  logic [$clog2(NUM_REGS)-1:0] i_issAddr,
`endif
    output logic [DATA_W-1:0]           o_data,
    output logic                        o_busy
);

`ifdef REGFILE_BYPASS_EN
    // A writeback hitting this port's address is forwarded straight away;
    // the busy bit it clears reads as clear unless an issue to the same
    // register re-marks it in this very cycle.
    always_comb begin
        o_data = i_regs[i_addr];
        o_busy = i_busy[i_addr];
        if (i_wbEn && (i_wbAddr == i_addr)) begin
            o_data = i_wbData;
            o_busy = i_issEn && (i_issAddr == i_addr);
        end
    end
`else
    // Plain read of stored state; writes become visible after the edge.
    always_comb begin
        o_data = i_regs[i_addr];
        o_busy = i_busy[i_addr];
    end
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Register file with a per-register pending-write scoreboard.
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset (regs <= index, marks cleared)
//   bus  : regfile_if.slave -- read ports, writeback, issue, flush, status
// Build option: REGFILE_BYPASS_EN enables same-cycle writeback forwarding
// on the read ports (see regfile_read_port).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF
) (
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [AW:0]         r_pendCnt;

    logic [NUM_REGS-1:0] w_busyNext;
    logic [AW:0]         w_cntNext;
    logic                w_inc;
    logic                w_dec;

    logic [DATA_W-1:0]   w_rdData [NUM_RD];
    logic                w_rdBusy [NUM_RD];

    // Next pending marks and count. Flush clears first, then an issue sets
    // its bit, so issue always wins over both flush and a colliding
    // writeback. The count moves incrementally: it only rises when an idle
    // register gets marked and only falls when a marked register is
    // retired without being re-marked, so it tracks popcount exactly and
    // can neither exceed NUM_REGS nor wrap below zero.
    always_comb begin
        w_busyNext = r_busy;
        w_cntNext  = r_pendCnt;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        if (bus.flush) begin
            w_busyNext = '0;
        end else if (bus.wb_en) begin
            w_busyNext[bus.wb_addr] = 1'b0;
        end
        if (bus.iss_en) begin
            w_busyNext[bus.iss_addr] = 1'b1;
        end
        if (bus.flush) begin
            w_cntNext = {{AW{1'b0}}, bus.iss_en};
        end else begin
            w_inc = bus.iss_en && !r_busy[bus.iss_addr];
            w_dec = bus.wb_en && r_busy[bus.wb_addr] &&
                    !(bus.iss_en && (bus.iss_addr == bus.wb_addr));
            w_cntNext = r_pendCnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
        end
    end

    // State registers. Reset drops any request present in the same cycle
    // and reloads every register with its own index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= DATA_W'(regResetValue(i));
            end
            r_busy    <= '0;
            r_pendCnt <= '0;
        end else begin
            if (bus.wb_en) begin
                r_regs[bus.wb_addr] <= bus.wb_data;
            end
            r_busy    <= w_busyNext;
            r_pendCnt <= w_cntNext;
        end
    end

    // One read port instance per requested port.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS)
        ) u_port (
            .i_addr    (bus.rd_addr[k*AW +: AW]),
            .i_regs    (r_regs),
            .i_busy    (r_busy),
`ifdef REGFILE_BYPASS_EN
            .i_wbEn    (bus.wb_en),
            .i_wbAddr  (bus.wb_addr),
            .i_wbData  (bus.wb_data),
            .i_issEn   (bus.iss_en),
            .i_issAddr (bus.iss_addr),
`endif
            .o_data    (w_rdData[k]),
            .o_busy    (w_rdBusy[k])
        );
    end

    // Pack per-port results onto the bus in a single driver.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            bus.rd_data[k*DATA_W +: DATA_W] = w_rdData[k];
            bus.rd_busy[k]                  = w_rdBusy[k];
        end
    end

    assign bus.busy_vec = r_busy;
    assign bus.pend_cnt = r_pendCnt;

endmodule
